// File: rtl/gelato_tensor_sched.sv
// Round-robin MMA scheduler for the Gelato tensor unit: grants one warp request,
// then steps the tensor unit through stages 0..7 with one writeback beat per stage.
module gelato_tensor_sched #(
  parameter int NUM_REQ   = 4,
  parameter int TAG_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rdy,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tu_start,
  output logic [2:0]                    tu_stage,
  input  logic                          tu_done,
  output logic                          wb_valid,
  output logic [TAG_WIDTH-1:0]          wb_tag,
  output logic [2:0]                    wb_stage,
  output logic                          wb_last,
  input  logic                          wb_ready,
  output logic                          busy,
  output logic [15:0]                   op_count
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [2:0]           stage_cnt_q, stage_cnt_d;
  logic [15:0]          op_count_q, op_count_d;
  logic                 done_pend_q, done_pend_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;

  logic                 grant_vld;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     cand;
  logic [TAG_WIDTH-1:0] sel_tag;

  // Walk downward so the candidate closest to rr_ptr is the one left standing.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    sel_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == PTR_W'(i)) sel_tag = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    stage_cnt_d = stage_cnt_q;
    op_count_d  = op_count_q;
    done_pend_d = done_pend_q;
    tag_d       = tag_q;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            tag_d       = sel_tag;
            rr_ptr_d    = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
            stage_cnt_d = 3'd0;
            state_d     = ISSUE;
          end
        end
        ISSUE: state_d = WAIT;
        WAIT: begin
          if (tu_done || done_pend_q) begin
            done_pend_d = 1'b0;
            state_d     = WB;
          end
        end
        WB: begin
          if (wb_ready) begin
            if (stage_cnt_q == 3'd7) begin
              op_count_d = op_count_q + 16'd1;
              state_d    = IDLE;
            end else begin
              stage_cnt_d = stage_cnt_q + 3'd1;
              state_d     = ISSUE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q == WAIT && tu_done) begin
      // A completion seen while frozen must survive until rdy returns.
      done_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      stage_cnt_q <= 3'd0;
      op_count_q  <= 16'd0;
      done_pend_q <= 1'b0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      stage_cnt_q <= stage_cnt_d;
      op_count_q  <= op_count_d;
      done_pend_q <= done_pend_d;
      tag_q       <= tag_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && rdy && grant_vld) req_ready[grant_idx] = 1'b1;
    tu_start = rdy && (state_q == ISSUE);
    tu_stage = tu_start ? stage_cnt_q : 3'd0;
    wb_valid = (state_q == WB);
    wb_stage = wb_valid ? stage_cnt_q : 3'd0;
    wb_last  = wb_valid && (stage_cnt_q == 3'd7);
    wb_tag   = tag_q;
    busy     = (state_q != IDLE);
    op_count = op_count_q;
  end
endmodule

// File: tb/tb_gelato_tensor_sched.sv
// Directed bench for gelato_tensor_sched with a latency-programmable tensor-unit stub.
module tb_gelato_tensor_sched;
  localparam int NUM_REQ   = 4;
  localparam int TAG_WIDTH = 5;

  logic                         clk = 1'b0;
  logic                         rst_n, rdy;
  logic [NUM_REQ-1:0]           req_valid, req_ready;
  logic [NUM_REQ*TAG_WIDTH-1:0] req_tag;
  logic                         tu_start, tu_done, wb_valid, wb_last, wb_ready, busy;
  logic [2:0]                   tu_stage, wb_stage;
  logic [TAG_WIDTH-1:0]         wb_tag;
  logic [15:0]                  op_count;

  logic stub_en, stub_done, man_done;
  int   stub_cnt, tu_lat;
  int   vecs, errs, exp_ops;

  gelato_tensor_sched #(.NUM_REQ(NUM_REQ), .TAG_WIDTH(TAG_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .req_valid(req_valid), .req_tag(req_tag),
    .req_ready(req_ready), .tu_start(tu_start), .tu_stage(tu_stage), .tu_done(tu_done),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_stage(wb_stage), .wb_last(wb_last),
    .wb_ready(wb_ready), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  assign tu_done = stub_done | man_done;

  // Tensor-unit stub: tu_done pulses tu_lat cycles after a sampled tu_start.
  always @(negedge clk) begin
    stub_done = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt = stub_cnt - 1;
      if (stub_cnt == 0) stub_done = 1'b1;
    end
    if (stub_en && tu_start) stub_cnt = tu_lat;
  end

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1; req_valid = '0; req_tag = '0; wb_ready = 1'b1;
    man_done = 1'b0; stub_en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vecs++; if (req_ready !== 4'b0) begin errs++; $display("FAIL rst_req_ready: got %0h want 0", req_ready); end
    vecs++; if (tu_start !== 1'b0) begin errs++; $display("FAIL rst_tu_start: got %0h want 0", tu_start); end
    vecs++; if (wb_valid !== 1'b0) begin errs++; $display("FAIL rst_wb_valid: got %0h want 0", wb_valid); end
    vecs++; if (wb_tag !== 5'h0) begin errs++; $display("FAIL rst_wb_tag: got %0h want 0", wb_tag); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %0h want 0", busy); end
    vecs++; if (op_count !== 16'h0) begin errs++; $display("FAIL rst_op_count: got %0h want 0", op_count); end
    rst_n = 1'b1;
    exp_ops = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int starts, beats, done_cyc;
    tu_lat = 6; stub_en = 1'b1; wb_ready = 1'b1;
    @(negedge clk);
    req_tag = {5'h00, 5'h11, 5'h00, 5'h00};
    req_valid = 4'b0100;
    #1;
    vecs++; if (req_ready !== 4'b0100) begin errs++; $display("FAIL single_grant: got %0h want 4", req_ready); end
    starts = 0; beats = 0; done_cyc = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      if (tu_start) begin
        vecs++; if (tu_stage !== 3'(starts)) begin errs++; $display("FAIL single_tu_stage: got %0d want %0d", tu_stage, starts); end
        starts++;
      end
      if (wb_valid) begin
        vecs++; if (wb_tag !== 5'h11) begin errs++; $display("FAIL single_wb_tag: got %0h want 11", wb_tag); end
        vecs++; if (wb_stage !== 3'(beats)) begin errs++; $display("FAIL single_wb_stage: got %0d want %0d", wb_stage, beats); end
        vecs++; if (wb_last !== (beats == 7)) begin errs++; $display("FAIL single_wb_last: got %0h at beat %0d", wb_last, beats); end
        beats++;
      end
      if (!busy) begin done_cyc = n; break; end
    end
    exp_ops++;
    vecs++; if (done_cyc != 65) begin errs++; $display("FAIL single_latency: got %0d want 65", done_cyc); end
    vecs++; if (starts != 8) begin errs++; $display("FAIL single_starts: got %0d want 8", starts); end
    vecs++; if (beats != 8) begin errs++; $display("FAIL single_beats: got %0d want 8", beats); end
    vecs++; if (op_count !== 16'(exp_ops)) begin errs++; $display("FAIL single_op_count: got %0h want %0h", op_count, exp_ops); end
    vecs++; if (dut.rr_ptr_q !== 2'd3) begin errs++; $display("FAIL single_rr_ptr: got %0d want 3", dut.rr_ptr_q); end
  endtask

  task automatic test_round_robin();
    int g;
    bit idle;
    logic [3:0] exp_rdy;
    logic [4:0] cur_tag;
    @(negedge clk); rst_n = 1'b0; #1;
    @(negedge clk); rst_n = 1'b1;
    exp_ops = 0; tu_lat = 1; stub_en = 1'b1; cur_tag = '0;
    req_tag = {5'h13, 5'h12, 5'h11, 5'h10};
    req_valid = 4'hF;
    g = 0;
    for (int n = 0; n < 400 && g < 5; n++) begin
      #1;
      if (busy) begin
        vecs++; if (req_ready !== 4'b0) begin errs++; $display("FAIL rr_ready_busy: got %0h want 0", req_ready); end
      end else if (req_ready !== 4'b0) begin
        exp_rdy = 4'b0001 << (g % 4);
        vecs++; if (req_ready !== exp_rdy) begin errs++; $display("FAIL rr_grant_%0d: got %0h want %0h", g, req_ready, exp_rdy); end
        cur_tag = 5'(16 + (g % 4));
        g++;
      end
      if (wb_valid) begin
        vecs++; if (wb_tag !== cur_tag) begin errs++; $display("FAIL rr_wb_tag: got %0h want %0h", wb_tag, cur_tag); end
      end
      if (g < 5) @(negedge clk);
    end
    vecs++; if (g != 5) begin errs++; $display("FAIL rr_timeout: got %0d grants want 5", g); end
    @(negedge clk);
    req_valid = '0;
    idle = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #1;
      if (!busy) begin idle = 1'b1; break; end
    end
    exp_ops = 5;
    vecs++; if (!idle) begin errs++; $display("FAIL rr_idle_timeout: got busy want idle"); end
    vecs++; if (op_count !== 16'(exp_ops)) begin errs++; $display("FAIL rr_op_count: got %0h want %0h", op_count, exp_ops); end
  endtask

  task automatic test_backpressure();
    bit found, idle;
    tu_lat = 1; stub_en = 1'b1; wb_ready = 1'b1;
    @(negedge clk);
    req_tag = {4{5'h0A}}; req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #1;
      if (wb_valid && wb_stage == 3'd3) begin found = 1'b1; break; end
    end
    vecs++; if (!found) begin errs++; $display("FAIL bp_stage3_timeout: got none want stage 3 beat"); end
    wb_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      vecs++; if (wb_valid !== 1'b1) begin errs++; $display("FAIL bp_wb_valid: got %0h want 1", wb_valid); end
      vecs++; if (wb_stage !== 3'd3) begin errs++; $display("FAIL bp_wb_stage: got %0d want 3", wb_stage); end
      vecs++; if (wb_tag !== 5'h0A) begin errs++; $display("FAIL bp_wb_tag: got %0h want a", wb_tag); end
      vecs++; if (tu_start !== 1'b0) begin errs++; $display("FAIL bp_no_start: got %0h want 0", tu_start); end
    end
    wb_ready = 1'b1;
    @(negedge clk); #1;
    vecs++; if (tu_start !== 1'b1 || tu_stage !== 3'd4) begin errs++; $display("FAIL bp_resume: got start %0h stage %0d want 1/4", tu_start, tu_stage); end
    vecs++; if (wb_valid !== 1'b0) begin errs++; $display("FAIL bp_dup_beat: got %0h want 0", wb_valid); end
    idle = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #1;
      if (!busy) begin idle = 1'b1; break; end
    end
    exp_ops++;
    vecs++; if (!idle) begin errs++; $display("FAIL bp_idle_timeout: got busy want idle"); end
    vecs++; if (op_count !== 16'(exp_ops)) begin errs++; $display("FAIL bp_op_count: got %0h want %0h", op_count, exp_ops); end
  endtask

  task automatic test_rdy_stall();
    int exp_stage;
    bit idle;
    stub_en = 1'b0; wb_ready = 1'b1;
    @(negedge clk);
    req_tag = {4{5'h07}}; req_valid = 4'b1000;
    @(negedge clk);
    req_valid = '0; #1;
    vecs++; if (tu_start !== 1'b1 || tu_stage !== 3'd0) begin errs++; $display("FAIL stall_issue: got start %0h stage %0d want 1/0", tu_start, tu_stage); end
    @(negedge clk);
    rdy = 1'b0; man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0; #1;
    vecs++; if (dut.done_pend_q !== 1'b1) begin errs++; $display("FAIL stall_done_pend: got %0h want 1", dut.done_pend_q); end
    vecs++; if (busy !== 1'b1 || wb_valid !== 1'b0) begin errs++; $display("FAIL stall_hold: got busy %0h wb_valid %0h want 1/0", busy, wb_valid); end
    @(negedge clk); #1;
    vecs++; if (wb_valid !== 1'b0 || dut.done_pend_q !== 1'b1) begin errs++; $display("FAIL stall_hold2: got wb_valid %0h pend %0h want 0/1", wb_valid, dut.done_pend_q); end
    rdy = 1'b1;
    @(negedge clk); #1;
    vecs++; if (wb_valid !== 1'b1 || wb_stage !== 3'd0) begin errs++; $display("FAIL stall_wb_enter: got valid %0h stage %0d want 1/0", wb_valid, wb_stage); end
    vecs++; if (wb_tag !== 5'h07) begin errs++; $display("FAIL stall_wb_tag: got %0h want 7", wb_tag); end
    vecs++; if (dut.done_pend_q !== 1'b0) begin errs++; $display("FAIL stall_pend_clear: got %0h want 0", dut.done_pend_q); end
    tu_lat = 1; stub_en = 1'b1;
    @(negedge clk); #1;
    vecs++; if (wb_valid !== 1'b0 || tu_start !== 1'b1 || tu_stage !== 3'd1) begin errs++; $display("FAIL stall_next: got valid %0h start %0h stage %0d want 0/1/1", wb_valid, tu_start, tu_stage); end
    exp_stage = 1; idle = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #1;
      if (wb_valid) begin
        vecs++; if (wb_stage !== 3'(exp_stage)) begin errs++; $display("FAIL stall_beat_order: got %0d want %0d", wb_stage, exp_stage); end
        exp_stage++;
      end
      if (!busy) begin idle = 1'b1; break; end
    end
    exp_ops++;
    vecs++; if (!idle || exp_stage != 8) begin errs++; $display("FAIL stall_beats: got %0d beats idle %0d want 8/1", exp_stage, idle); end
    vecs++; if (op_count !== 16'(exp_ops)) begin errs++; $display("FAIL stall_op_count: got %0h want %0h", op_count, exp_ops); end
  endtask

  task automatic test_reset_mid();
    bit found, idle;
    tu_lat = 2; stub_en = 1'b1;
    @(negedge clk);
    req_tag = {4{5'h15}}; req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk); #1;
      if (tu_start && tu_stage == 3'd5) begin found = 1'b1; break; end
    end
    vecs++; if (!found) begin errs++; $display("FAIL rmid_stage5_timeout: got none want stage 5"); end
    rst_n = 1'b0; stub_en = 1'b0; stub_cnt = 0;
    #1;
    vecs++; if (tu_start !== 1'b0 || tu_stage !== 3'd0) begin errs++; $display("FAIL rmid_tu: got start %0h stage %0d want 0/0", tu_start, tu_stage); end
    vecs++; if (wb_valid !== 1'b0 || wb_stage !== 3'd0 || wb_last !== 1'b0) begin errs++; $display("FAIL rmid_wb: got %0h/%0d/%0h want 0/0/0", wb_valid, wb_stage, wb_last); end
    vecs++; if (wb_tag !== 5'h0) begin errs++; $display("FAIL rmid_wb_tag: got %0h want 0", wb_tag); end
    vecs++; if (busy !== 1'b0 || req_ready !== 4'b0) begin errs++; $display("FAIL rmid_idle: got busy %0h ready %0h want 0/0", busy, req_ready); end
    vecs++; if (op_count !== 16'h0) begin errs++; $display("FAIL rmid_op_count: got %0h want 0", op_count); end
    exp_ops = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stub_en = 1'b1;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0; #1;
    vecs++; if (tu_start !== 1'b1 || tu_stage !== 3'd0) begin errs++; $display("FAIL rmid_restart: got start %0h stage %0d want 1/0", tu_start, tu_stage); end
    idle = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk); #1;
      if (!busy) begin idle = 1'b1; break; end
    end
    exp_ops++;
    vecs++; if (!idle) begin errs++; $display("FAIL rmid_idle_timeout: got busy want idle"); end
    vecs++; if (op_count !== 16'(exp_ops)) begin errs++; $display("FAIL rmid_op_count2: got %0h want %0h", op_count, exp_ops); end
  endtask

  task automatic test_wrap();
    bit idle;
    tu_lat = 1; stub_en = 1'b1;
    @(negedge clk);
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    @(negedge clk); #1;
    vecs++; if (op_count !== 16'hFFFF) begin errs++; $display("FAIL wrap_preload: got %0h want ffff", op_count); end
    req_tag = {4{5'h1F}}; req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    idle = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #1;
      if (!busy) begin idle = 1'b1; break; end
    end
    vecs++; if (!idle) begin errs++; $display("FAIL wrap_idle_timeout: got busy want idle"); end
    vecs++; if (op_count !== 16'h0000) begin errs++; $display("FAIL wrap_op_count: got %0h want 0", op_count); end
  endtask

  initial begin
    vecs = 0; errs = 0; exp_ops = 0;
    stub_cnt = 0; stub_done = 1'b0; stub_en = 1'b0; man_done = 1'b0; tu_lat = 1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_rdy_stall();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
